// File: rtl/tmul_tile_loader.sv
// Assembles one operand tile (vector a, matrix b) from a serial word stream and
// holds it for the tile multiplier behind a valid/ready handshake.
module tmul_tile_loader #(
  parameter int unsigned DW    = 32,
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic [N*DW-1:0]       a_out,
  output logic [N*N*DW-1:0]     b_out,
  output logic [6:0]            load_idx,
  output logic [CNT_W-1:0]      tile_count
);

  localparam int unsigned LAST_IDX = N + N*N - 1;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    HOLD
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   handoff;

  assign accept  = in_valid && in_ready;
  assign handoff = tile_valid && tile_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A: if (accept && load_idx == 7'(N - 1)) state_nxt = LOAD_B;
      LOAD_B: if (accept && load_idx == 7'(LAST_IDX)) state_nxt = HOLD;
      HOLD:   if (tile_ready) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
  end

  always_comb begin
    in_ready   = (state != HOLD) && !rst;
    tile_valid = (state == HOLD);
  end

  // Row-major b packing makes the flat slot offset (idx-N)*DW, so each index
  // decodes to exactly one DW-wide field across a_out then b_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_idx   <= '0;
      a_out      <= '0;
      b_out      <= '0;
      tile_count <= '0;
    end else begin
      if (accept) begin
        load_idx <= (load_idx == 7'(LAST_IDX)) ? '0 : load_idx + 7'd1;
        for (int unsigned i = 0; i < N; i++) begin
          if (load_idx == 7'(i)) a_out[i*DW +: DW] <= in_data;
        end
        for (int unsigned i = 0; i < N*N; i++) begin
          if (load_idx == 7'(N + i)) b_out[i*DW +: DW] <= in_data;
        end
      end
      if (handoff) begin
        tile_count <= tile_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tmul_tile_loader.sv
// Randomized bench for tmul_tile_loader: word-level reference model plus a
// tile scoreboard checked at every presented/handed-off tile.
module tb_tmul_tile_loader;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int CW = 2;
  localparam int TS = N + N*N;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              tile_valid;
  logic              tile_ready;
  logic [N*DW-1:0]   a_out;
  logic [N*N*DW-1:0] b_out;
  logic [6:0]        load_idx;
  logic [CW-1:0]     tile_count;

  tmul_tile_loader #(.DW(DW), .N(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .a_out(a_out), .b_out(b_out), .load_idx(load_idx), .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // reference model: words land in slots in arrival order; tile complete after TS words
  logic [DW-1:0]      img [TS];
  int                 m_fill = 0;
  bit                 m_hold = 0;
  int                 m_cnt  = 0;
  bit                 armed  = 0;
  logic [TS*DW-1:0]   sb_q [$];
  int                 rises [$];
  logic               prev_tv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_tile(input string name, input logic [TS*DW-1:0] exp_t);
    logic [TS*DW-1:0] act, e;
    int bad;
    logic [DW-1:0] got, want;
    act = {b_out, a_out};
    e   = exp_t;
    bad = -1;
    got = '0;
    want = '0;
    for (int i = 0; i < TS; i++) begin
      if (bad < 0 && act[DW-1:0] !== e[DW-1:0]) begin
        bad = i; got = act[DW-1:0]; want = e[DW-1:0];
      end
      act = act >> DW;
      e   = e >> DW;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: slot %0d got %0h expected %0h", name, bad, got, want);
    end
  endtask

  function automatic logic [TS*DW-1:0] pack_img();
    logic [TS*DW-1:0] t;
    t = '0;
    for (int i = 0; i < TS; i++) t = {img[i], t[TS*DW-1:DW]};
    return t;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready",   64'(in_ready),   64'(!rst && !m_hold));
      chk("tile_valid", 64'(tile_valid), 64'(m_hold));
      chk("load_idx",   64'(load_idx),   64'(m_fill));
      chk("tile_count", 64'(tile_count), 64'(m_cnt % (1 << CW)));
      chk_tile("image", pack_img());
    end
    if (rst) begin
      m_fill = 0; m_hold = 0; m_cnt = 0;
      for (int i = 0; i < TS; i++) img[i] = '0;
      sb_q.delete();
      armed = 1;
    end else if (armed) begin
      if (m_hold) begin
        if (tile_ready) begin m_hold = 0; m_cnt++; end
      end else if (in_valid) begin
        img[m_fill] = in_data;
        m_fill++;
        if (m_fill == TS) begin
          m_fill = 0; m_hold = 1;
          sb_q.push_back(pack_img());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !rst && tile_valid) begin
      if (!prev_tv) rises.push_back(cyc);
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got tile_valid=1 expected no tile");
      end else begin
        chk_tile("sb_tile", sb_q[0]);
        if (tile_ready) void'(sb_q.pop_front());
      end
    end
    prev_tv = tile_valid;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] w);
    bit got;
    got = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no in_ready expected accept of %0h", w);
    end
  endtask

  task automatic check_tile_consts(input string tag, input logic [DW-1:0] a0, input logic [DW-1:0] b77);
    @(negedge clk);
    chk({tag, "_tv"},   64'(tile_valid), 64'd1);
    chk({tag, "_ir"},   64'(in_ready),   64'd0);
    chk({tag, "_a0"},   64'(a_out[31:0]), 64'(a0));
    chk({tag, "_b77"},  64'(b_out[2047:2016]), 64'(b77));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = $urandom; tile_ready = 1'b0;
    tick; tick;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_tv",       64'(tile_valid), 64'd0);
    chk("rst_a_zero",   64'(a_out == '0), 64'd1);
    chk("rst_b_zero",   64'(b_out == '0), 64'd1);
    chk("rst_idx",      64'(load_idx), 64'd0);
    chk("rst_cnt",      64'(tile_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // continuous load of 1..72
    @(posedge clk); #1;
    for (int w = 1; w <= TS; w++) send(DW'(w));
    check_tile_consts("cont", 32'd1, 32'd72);
    chk("cont_a7",  64'(a_out[255:224]), 64'd8);
    chk("cont_b00", 64'(b_out[31:0]),    64'd9);
    chk("cont_b17", 64'(b_out[511:480]), 64'd24);

    // back-pressure with junk words offered
    tick;
    in_valid = 1'b1; in_data = 32'hDEAD;
    repeat (5) tick;
    @(negedge clk);
    chk("bp_idx", 64'(load_idx), 64'd0);
    chk("bp_a0",  64'(a_out[31:0]), 64'd1);
    tick;
    tile_ready = 1'b1;
    tick;
    tile_ready = 1'b0; in_data = 32'd1;
    @(negedge clk);
    chk("ho_tv",    64'(tile_valid), 64'd0);
    chk("ho_cnt",   64'(tile_count), 64'd1);
    chk("ho_ready", 64'(in_ready),   64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ho_idx", 64'(load_idx), 64'd1);

    // remaining words with bubbles and junk on idle cycles
    @(posedge clk); #1;
    for (int w = 2; w <= TS; w++) begin
      tick;
      send(DW'(w));
    end
    check_tile_consts("bub", 32'd1, 32'd72);
    chk("bub_b17", 64'(b_out[511:480]), 64'd24);
    tick;
    tile_ready = 1'b1;
    tick;
    tile_ready = 1'b0;

    // reset mid-load
    for (int i = 0; i < 30; i++) send($urandom);
    rst = 1'b1; in_valid = 1'b1; in_data = $urandom;
    tick;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_idx",   64'(load_idx), 64'd0);
    chk("mid_cnt",   64'(tile_count), 64'd0);
    chk("mid_azero", 64'(a_out == '0), 64'd1);
    @(posedge clk); #1;
    tile_ready = 1'b1;
    for (int w = 101; w <= 172; w++) send(DW'(w));
    check_tile_consts("rl", 32'd101, 32'd172);
    tick;

    // counter wrap and tile period, back-to-back
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rises.delete();
    for (int t = 0; t < 5; t++)
      for (int i = 0; i < TS; i++) send($urandom);
    tick; tick;
    @(negedge clk);
    chk("wrap_cnt", 64'(tile_count), 64'd1);
    chk("rise_n",   64'(rises.size()), 64'd5);
    for (int i = 1; i < rises.size(); i++)
      chk("period", 64'(rises[i] - rises[i-1]), 64'd73);

    // random traffic with occasional resets
    @(posedge clk); #1;
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom % 4) != 0;
      in_data    = $urandom;
      tile_ready = ($urandom % 3) == 0;
      rst        = ($urandom % 400) == 0;
      tick;
    end
    rst = 1'b0; in_valid = 1'b0; tile_ready = 1'b0;
    tick; tick;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmul_tile_loader.md
Name: tmul_tile_loader

Overview:
Producer side of the tile-multiply operand interface. It takes a serial stream of 32-bit words and assembles one operand tile: the vector a[0..7] and the matrix b[0..7][0..7], with each matrix row packed into 256 bits. It holds the completed tile stable and hands it to the 8x8 tile multiplier through a valid/ready handshake. It sits between the operand memory/DMA stream and the multiplier's a/b inputs.

Parameters:
DW, 32, element width in bits
N, 8, vector length and matrix dimension; tile size is N + N*N words
CNT_W, 16, width of the delivered-tile counter

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data carries a valid word
in_ready  output  1  loader accepts a word this cycle
in_data  input  DW  operand word; order is a[0..N-1], then b row-major (b[0][0..N-1], b[1][0..N-1], ...)
tile_valid  output  1  a_out and b_out hold a complete tile
tile_ready  input  1  multiplier consumes the tile this cycle
a_out  output  N*DW  a[i] at bits [DW*i+DW-1 : DW*i]
b_out  output  N*N*DW  row j at [N*DW*j+N*DW-1 : N*DW*j]; b[j][k] at row offset [DW*k+DW-1 : DW*k] (same packing the multiplier expects per row)
load_idx  output  7  index of the next word to be accepted, 0..N+N*N-1
tile_count  output  CNT_W  number of tiles handed off; wraps modulo 2^CNT_W

Behaviour:
- States: LOAD_A, LOAD_B, HOLD.
- Reset (rst high at a clock edge): state LOAD_A; load_idx 0; tile_valid 0; a_out 0; b_out 0; tile_count 0. in_ready is forced to 0 in any cycle where rst is high.
- in_ready = (state != HOLD) && !rst. It is combinational from state and does not depend on in_valid.
- An accept is in_valid && in_ready at a clock edge. An accept writes in_data into the slot addressed by load_idx, then load_idx increments.
- LOAD_A: idx 0..N-1 write a[idx]. The accept at idx N-1 moves the state to LOAD_B.
- LOAD_B: idx N..N+N*N-1 write b[(idx-N)/N][(idx-N)%N]. The accept at the last idx (71 at defaults) moves the state to HOLD, sets tile_valid=1, and resets load_idx to 0.
- Latency: tile_valid is high in the cycle after the final accepting edge. The minimum tile period with continuous input and tile_ready held high is N+N*N+1 cycles (73 at defaults).
- Gaps in in_valid stall the load without side effects. in_data is ignored when not accepted.
- HOLD: in_ready=0, and a_out/b_out are stable. in_valid is ignored and no words are lost, because the upstream source must hold them.
- On tile_valid && tile_ready at an edge: tile_valid goes to 0, the state goes to LOAD_A, and tile_count increments, wrapping from 2^CNT_W-1 to 0.
- tile_valid must not drop without tile_ready. tile_ready while tile_valid=0 has no effect.
- a_out/b_out are not cleared between tiles. Slots are overwritten as new words arrive, so the multiplier may sample them only while tile_valid=1.
- Single buffer: no accepts occur in the handoff cycle itself. in_ready rises in the cycle after the tile_ready handshake.
- Reset during LOAD_A, LOAD_B or HOLD takes priority over every other event. The partial or held tile is discarded and all registers return to reset values.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0, tile_valid=0, a_out=0, b_out=0, load_idx=0, tile_count=0; in the first cycle after release, in_ready=1.
- Full load, continuous: send words 1..72 on consecutive cycles with tile_ready=0 -> tile_valid rises the cycle after word 72. Expected contents: a_out[31:0]=1, a_out[255:224]=8, b_out[31:0]=9 (b[0][0]), b_out[511:480]=24 (b[1][7]), b_out[2047:2016]=72 (b[7][7]); in_ready=0.
- Bubbles: same 72 words with in_valid toggling 1,0,1,0... and varying in_data on the idle cycles -> identical a_out/b_out to the continuous case; tile_valid follows the 72nd accept by 1 cycle.
- Back-pressure: tile complete, tile_ready=0 for 5 cycles with in_valid=1 and in_data=0xDEAD -> outputs unchanged and load_idx=0. Then tile_ready=1 for 1 cycle -> tile_valid=0, tile_count=1, in_ready=1 next cycle; next word accepted into a[0].
- Reset mid-load: accept 30 words, assert rst 1 cycle -> all reset values. A following 72-word load (values 101..172) gives a_out[31:0]=101 and b_out[2047:2016]=172.
- Counter wrap with CNT_W=2: deliver 5 tiles back-to-back with tile_ready=1 -> tile_count sequence 1,2,3,0,1; tile period 73 cycles.
